// File: rtl/pipe_pkg.sv
// Shared constants for the generic pipeline stage register: control bit indices,
// the default EX/MEM data bundle layout and per-stage bundle widths.
package pipe_pkg;

  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMTOREG = 1;
  localparam int CTRL_BRANCH   = 2;
  localparam int CTRL_MEMREAD  = 3;
  localparam int CTRL_MEMWRITE = 4;
  localparam int CTRL_ZERO     = 5;

  // EX/MEM data bundle, packed LSB first: RegisterRd, Instruction, rd_data_2, ALU_result, ADD_result
  localparam int EXMEM_RD_W     = 5;
  localparam int EXMEM_INSTR_W  = 5;
  localparam int EXMEM_RDDATA_W = 64;
  localparam int EXMEM_ALU_W    = 64;
  localparam int EXMEM_ADD_W    = 64;

  localparam int EXMEM_RD_OFS     = 0;
  localparam int EXMEM_INSTR_OFS  = EXMEM_RD_OFS + EXMEM_RD_W;
  localparam int EXMEM_RDDATA_OFS = EXMEM_INSTR_OFS + EXMEM_INSTR_W;
  localparam int EXMEM_ALU_OFS    = EXMEM_RDDATA_OFS + EXMEM_RDDATA_W;
  localparam int EXMEM_ADD_OFS    = EXMEM_ALU_OFS + EXMEM_ALU_W;

  localparam int IFID_CTRL_W  = 1;
  localparam int IFID_DATA_W  = 96;
  localparam int IDEX_CTRL_W  = 9;
  localparam int IDEX_DATA_W  = 266;
  localparam int EXMEM_CTRL_W = 6;
  localparam int EXMEM_DATA_W = EXMEM_ADD_OFS + EXMEM_ADD_W;
  localparam int MEMWB_CTRL_W = 2;
  localparam int MEMWB_DATA_W = 133;

  function automatic logic [1:0] count_valid(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle between an upstream stage, the stage register and the downstream stage.
interface pipe_stage_skid_if #(
  parameter int CTRL_W = 6,
  parameter int DATA_W = 202
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;

  modport slave (
    input  flush, in_valid, in_ctrl, in_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_data, occupancy
  );

  modport master (
    output flush, in_valid, in_ctrl, in_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data, occupancy
  );
endinterface

// File: rtl/pipe_stage_skid_slot.sv
// One registered entry (valid + ctrl + data). Load wins over clear; clear drops only
// the valid bit so the payload may go stale.
module pipe_slot #(
  parameter int CTRL_W = 6,
  parameter int DATA_W = 202
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clear,
  input  logic              i_load,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_ctrl  <= i_ctrl;
      r_data  <= i_data;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_ctrl  = r_ctrl;
  assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_skid.sv
// Handshaked pipeline stage register with a two-entry (main + skid) buffer, flush
// bubble insertion and a registered in_ready.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int                CTRL_W      = 6,
  parameter int                DATA_W      = 202,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0
) (
  input logic                 clk,
  input logic                 reset,
  pipe_stage_skid_if.slave    bus
);

  logic              w_main_valid, w_skid_valid;
  logic [CTRL_W-1:0] w_main_ctrl, w_skid_ctrl, w_main_ctrl_d;
  logic [DATA_W-1:0] w_main_data, w_skid_data, w_main_data_d;
  logic              w_in_fire, w_out_fire;
  logic              w_main_load, w_main_clear, w_skid_load, w_skid_clear;
  logic              w_skid_valid_next;
  logic              r_in_ready;

  assign w_in_fire  = bus.in_valid & r_in_ready & ~bus.flush;
  assign w_out_fire = w_main_valid & bus.out_ready;

  // Main refills from skid when skid holds the older entry, otherwise from the input
  assign w_main_load  = ~bus.flush & ((w_in_fire & (~w_main_valid | (w_out_fire & ~w_skid_valid)))
                                      | (w_skid_valid & w_out_fire));
  assign w_main_clear = bus.flush | (w_main_valid & w_out_fire & ~w_skid_valid & ~w_in_fire);
  assign w_skid_load  = w_in_fire & w_main_valid & ~w_out_fire;
  assign w_skid_clear = bus.flush | (w_skid_valid & w_out_fire);

  assign w_main_ctrl_d = w_skid_valid ? w_skid_ctrl : bus.in_ctrl;
  assign w_main_data_d = w_skid_valid ? w_skid_data : bus.in_data;

  assign w_skid_valid_next = w_skid_load | (w_skid_valid & ~w_skid_clear);

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_main_clear),
    .i_load  (w_main_load),
    .i_ctrl  (w_main_ctrl_d),
    .i_data  (w_main_data_d),
    .o_valid (w_main_valid),
    .o_ctrl  (w_main_ctrl),
    .o_data  (w_main_data)
  );

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_skid_clear),
    .i_load  (w_skid_load),
    .i_ctrl  (bus.in_ctrl),
    .i_data  (bus.in_data),
    .o_valid (w_skid_valid),
    .o_ctrl  (w_skid_ctrl),
    .o_data  (w_skid_data)
  );

  // Registered ready keeps out_ready off the upstream timing path
  always_ff @(posedge clk) begin
    if (reset) r_in_ready <= 1'b1;
    else       r_in_ready <= ~w_skid_valid_next;
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = w_main_valid;
  assign bus.out_ctrl  = w_main_valid ? w_main_ctrl : BUBBLE_CTRL;
  assign bus.out_data  = w_main_data;
  assign bus.occupancy = count_valid(w_main_valid, w_skid_valid);

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: a queue of held entries models the stage,
// a negedge monitor compares the DUT head and flags against it.
module tb_pipe_stage_skid;
  import pipe_pkg::*;

  localparam int CW = EXMEM_CTRL_W;
  localparam int DW = EXMEM_DATA_W;

  typedef struct {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
  } entry_t;

  logic clk = 1'b0;
  logic reset;

  pipe_stage_skid_if #(.CTRL_W(CW), .DATA_W(DW)) bus ();

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .BUBBLE_CTRL('0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  entry_t q[$];
  logic   modelReady = 1'b1;
  logic   checking   = 1'b0;
  int     compared   = 0;
  int     mismatched = 0;

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                               input logic ordy, input logic fl, input logic rst);
    @(posedge clk);
    #1;
    bus.in_valid  = v;
    bus.in_ctrl   = c;
    bus.in_data   = d;
    bus.out_ready = ordy;
    bus.flush     = fl;
    reset         = rst;
  endtask

  task automatic idle(input logic ordy);
    applyStimulus(1'b0, '0, '0, ordy, 1'b0, 1'b0);
  endtask

  // Offer an entry until the model says the stage accepts it on the next edge
  task automatic sendEntry(input logic [CW-1:0] c, input logic [DW-1:0] d, input logic ordy);
    int tries;
    tries = 0;
    forever begin
      applyStimulus(1'b1, c, d, ordy, 1'b0, 1'b0);
      if (modelReady) break;
      tries++;
      if (tries > 50) begin
        checkOutput("send_timeout", 256'd1, 256'd0);
        break;
      end
    end
  endtask

  function automatic logic [DW-1:0] randData(input int seq);
    logic [223:0] w;
    w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    w[15:0] = seq[15:0];
    return w[DW-1:0];
  endfunction

  // Reference model: held entries are a FIFO of depth two, emptied by flush or reset
  initial forever begin
    @(posedge clk);
    if (reset) begin
      q.delete();
      modelReady = 1'b1;
      checking   = 1'b1;
    end else if (bus.flush) begin
      q.delete();
      modelReady = 1'b1;
    end else begin
      if (bus.in_valid && modelReady) q.push_back('{ctrl: bus.in_ctrl, data: bus.in_data});
      modelReady = (q.size() < 2);
    end
  end

  // Monitor: compare the presented head and flags, then retire on a downstream accept
  initial forever begin
    @(negedge clk);
    if (checking) begin
      checkOutput("occupancy", {254'd0, bus.occupancy}, q.size());
      checkOutput("in_ready", {255'd0, bus.in_ready}, {255'd0, modelReady});
      checkOutput("out_valid", {255'd0, bus.out_valid}, {255'd0, q.size() != 0});
      if (q.size() != 0) begin
        checkOutput("out_ctrl", {250'd0, bus.out_ctrl}, {250'd0, q[0].ctrl});
        checkOutput("out_data", {54'd0, bus.out_data}, {54'd0, q[0].data});
        if (bus.out_ready && !reset) void'(q.pop_front());
      end else begin
        checkOutput("out_ctrl_bubble", {250'd0, bus.out_ctrl}, 256'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    mismatched++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    logic              pendValid;
    logic [CW-1:0]     pendCtrl;
    logic [DW-1:0]     pendData;
    logic              fl;
    int                seq;

    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_ctrl = '0; bus.in_data = '0;
    bus.out_ready = 1'b0; bus.flush = 1'b0;

    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    @(negedge clk);
    checkOutput("reset_out_data", {54'd0, bus.out_data}, 256'd0);
    checkOutput("reset_in_ready", {255'd0, bus.in_ready}, 256'd1);

    $display("[TB] stream 1..4");
    sendEntry(6'h01, 202'd1, 1'b1);
    for (int i = 2; i <= 4; i++) begin
      sendEntry(6'h01, DW'(i), 1'b1);
      @(negedge clk);
      checkOutput("stream_occ", {254'd0, bus.occupancy}, 256'd1);
      checkOutput("stream_data", {54'd0, bus.out_data}, 256'(i - 1));
    end
    idle(1'b1); idle(1'b1);

    $display("[TB] back-pressure 10,11,12");
    sendEntry(6'h02, 202'd10, 1'b1);
    sendEntry(6'h02, 202'd11, 1'b0);
    applyStimulus(1'b1, 6'h02, 202'd12, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("bp_occ", {254'd0, bus.occupancy}, 256'd2);
    checkOutput("bp_ready", {255'd0, bus.in_ready}, 256'd0);
    checkOutput("bp_head", {54'd0, bus.out_data}, 256'd10);
    sendEntry(6'h02, 202'd12, 1'b1);
    repeat (4) idle(1'b1);

    $display("[TB] flush with two held");
    sendEntry(6'h0A, 202'hA, 1'b0);
    sendEntry(6'h0B, 202'hB, 1'b0);
    applyStimulus(1'b1, 6'h0C, 202'hC, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    @(negedge clk);
    checkOutput("flush_valid", {255'd0, bus.out_valid}, 256'd0);
    checkOutput("flush_ctrl", {250'd0, bus.out_ctrl}, 256'd0);
    checkOutput("flush_occ", {254'd0, bus.occupancy}, 256'd0);
    checkOutput("flush_ready", {255'd0, bus.in_ready}, 256'd1);
    repeat (3) idle(1'b1);

    $display("[TB] bubble masking");
    sendEntry(6'h3F, 202'h55, 1'b1);
    idle(1'b1);
    idle(1'b1);
    @(negedge clk);
    checkOutput("bubble_valid", {255'd0, bus.out_valid}, 256'd0);
    checkOutput("bubble_ctrl", {250'd0, bus.out_ctrl}, 256'd0);

    $display("[TB] reset priority");
    sendEntry(6'h11, 202'h77, 1'b0);
    sendEntry(6'h12, 202'h78, 1'b0);
    applyStimulus(1'b1, 6'h13, 202'h79, 1'b1, 1'b1, 1'b1);
    idle(1'b0);
    @(negedge clk);
    checkOutput("rst_valid", {255'd0, bus.out_valid}, 256'd0);
    checkOutput("rst_data", {54'd0, bus.out_data}, 256'd0);
    checkOutput("rst_occ", {254'd0, bus.occupancy}, 256'd0);
    checkOutput("rst_ready", {255'd0, bus.in_ready}, 256'd1);
    sendEntry(6'h21, 202'hDEAD, 1'b1);
    idle(1'b1);
    @(negedge clk);
    checkOutput("dead_data", {54'd0, bus.out_data}, 256'hDEAD);
    checkOutput("dead_occ", {254'd0, bus.occupancy}, 256'd1);
    idle(1'b1);
    @(negedge clk);
    checkOutput("dead_alone", {255'd0, bus.out_valid}, 256'd0);

    $display("[TB] random soak");
    pendValid = 1'b0; pendCtrl = '0; pendData = '0; seq = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if (!pendValid && $urandom_range(99) < 60) begin
        pendValid = 1'b1;
        pendCtrl  = CW'($urandom);
        pendData  = randData(seq);
        seq++;
      end
      fl = ($urandom_range(99) < 2);
      applyStimulus(pendValid, pendCtrl, pendData, $urandom_range(99) < 70, fl, 1'b0);
      if (pendValid && (modelReady || fl)) pendValid = 1'b0;
    end
    repeat (4) idle(1'b1);
    @(negedge clk);
    checkOutput("drain_occ", {254'd0, bus.occupancy}, 256'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
